// File: rtl/stack_test_pkg.sv
// Shared definitions for the 3D-stack self-test ID chain: frame layout,
// collector states and error codes. The layer-side encoder imports this too.
package stack_test_pkg;

    localparam logic [3:0]  SYNC_NIBBLE = 4'hA;
    localparam logic [15:0] FRAME_MAGIC = 16'hBEEF;

    localparam int unsigned SYNC_HI   = 31;
    localparam int unsigned SYNC_LO   = 28;
    localparam int unsigned POWER_HI  = 27;
    localparam int unsigned POWER_LO  = 24;
    localparam int unsigned SENDER_HI = 23;
    localparam int unsigned SENDER_LO = 20;
    localparam int unsigned NEXT_HI   = 19;
    localparam int unsigned NEXT_LO   = 16;
    localparam int unsigned MAGIC_HI  = 15;
    localparam int unsigned MAGIC_LO  = 0;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DONE,
        ERROR
    } state_t;

    typedef logic [1:0] err_code_t;

    localparam err_code_t ERR_NONE   = 2'd0;
    localparam err_code_t ERR_FRAME  = 2'd1;
    localparam err_code_t ERR_SEQ    = 2'd2;
    localparam err_code_t ERR_NORESP = 2'd3;

    // Chip IDs wrap in 4 bits, so the top layer (15) announces next=0.
    function automatic logic [3:0] next_id(input logic [3:0] id);
        return id + 4'd1;
    endfunction

endpackage

// File: rtl/stack_id_collector_if.sv
// Shared inter-layer bus as seen by the base-side collector.
interface stack_id_collector_if;

    logic        rx_valid;
    logic [31:0] data_in;

    modport master (output rx_valid, output data_in);
    modport slave  (input  rx_valid, input  data_in);

endinterface

// File: rtl/stack_power_table.sv
// Per-chip power register file; chip IDs are 1-based, ID 0 and out-of-range reads return 0.
module stack_power_table #(
    parameter int unsigned DEPTH = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       we,
    input  logic [3:0] waddr,
    input  logic [3:0] wdata,
    input  logic [3:0] raddr,
    output logic [3:0] rdata
);

    logic [3:0] mem_q [DEPTH];
    logic [3:0] mem_d [DEPTH];

    always_comb begin
        mem_d = mem_q;
        if (clr) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_d[i] = '0;
            end
        end else if (we && waddr != '0 && 32'(waddr) <= DEPTH) begin
            mem_d[waddr - 4'd1] = wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q <= '{default: '0};
        end else begin
            mem_q <= mem_d;
        end
    end

    assign rdata = (raddr != '0 && 32'(raddr) <= DEPTH) ? mem_q[raddr - 4'd1] : '0;

endmodule

// File: rtl/stack_id_collector.sv
// Base-side listener for the stack ID chain: checks the announce sequence,
// records each layer's power value and declares the stack enumerated on silence.
module stack_id_collector
    import stack_test_pkg::*;
#(
    parameter int unsigned MAX_CHIPS = 15,
    parameter int unsigned TIMEOUT   = 64,
    parameter int unsigned RETRY_W   = 6
) (
    input  logic                 div_8_clk,
    input  logic                 rst,
    input  logic                 start,
    stack_id_collector_if.slave  bus,
    input  logic [3:0]           rd_addr,
    output logic [3:0]           rd_power,
    output logic [3:0]           chip_count,
    output logic [RETRY_W-1:0]   retry_cnt,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic [1:0]           err_code
);

    localparam int unsigned TIMER_W = $clog2(TIMEOUT);

    state_t               state_q,      state_d;
    logic [3:0]           exp_id_q,     exp_id_d;
    logic [3:0]           chip_count_q, chip_count_d;
    logic [RETRY_W-1:0]   retry_cnt_q,  retry_cnt_d;
    logic [TIMER_W-1:0]   timer_q,      timer_d;
    err_code_t            err_code_q,   err_code_d;

    logic       tbl_we;
    logic       tbl_clr;
    logic [3:0] f_sync;
    logic [3:0] f_power;
    logic [3:0] f_sender;
    logic [3:0] f_next;
    logic       frame_seen;

    assign f_sync     = bus.data_in[SYNC_HI:SYNC_LO];
    assign f_power    = bus.data_in[POWER_HI:POWER_LO];
    assign f_sender   = bus.data_in[SENDER_HI:SENDER_LO];
    assign f_next     = bus.data_in[NEXT_HI:NEXT_LO];
    assign frame_seen = bus.rx_valid && (bus.data_in[MAGIC_HI:MAGIC_LO] == FRAME_MAGIC);

    always_comb begin
        state_d      = state_q;
        exp_id_d     = exp_id_q;
        chip_count_d = chip_count_q;
        retry_cnt_d  = retry_cnt_q;
        timer_d      = timer_q;
        err_code_d   = err_code_q;
        tbl_we       = 1'b0;
        tbl_clr      = 1'b0;

        if (start) begin
            state_d      = WAIT;
            exp_id_d     = 4'd1;
            chip_count_d = '0;
            retry_cnt_d  = '0;
            timer_d      = '0;
            err_code_d   = ERR_NONE;
            tbl_clr      = 1'b1;
        end else if (state_q == WAIT) begin
            // An accepted frame takes precedence over a timeout in the same cycle.
            if (frame_seen) begin
                if (f_sync != SYNC_NIBBLE) begin
                    state_d    = ERROR;
                    err_code_d = ERR_FRAME;
                end else if (f_sender == exp_id_q && f_next == next_id(f_sender)) begin
                    tbl_we       = 1'b1;
                    chip_count_d = f_sender;
                    exp_id_d     = exp_id_q + 4'd1;
                    timer_d      = '0;
                    if (f_sender == 4'(MAX_CHIPS)) begin
                        state_d    = ERROR;
                        err_code_d = ERR_NORESP;
                    end
                end else if (chip_count_q != '0 && f_sender == chip_count_q &&
                             f_next == next_id(f_sender)) begin
                    tbl_we  = 1'b1;
                    timer_d = '0;
                    if (retry_cnt_q != '1) begin
                        retry_cnt_d = retry_cnt_q + 1'b1;
                    end
                end else begin
                    state_d    = ERROR;
                    err_code_d = ERR_SEQ;
                end
            end else if (timer_q == TIMER_W'(TIMEOUT - 1)) begin
                if (chip_count_q != '0) begin
                    state_d = DONE;
                end else begin
                    state_d    = ERROR;
                    err_code_d = ERR_NORESP;
                end
            end else begin
                timer_d = timer_q + 1'b1;
            end
        end
    end

    always_ff @(posedge div_8_clk) begin
        if (rst) begin
            state_q      <= IDLE;
            exp_id_q     <= 4'd1;
            chip_count_q <= '0;
            retry_cnt_q  <= '0;
            timer_q      <= '0;
            err_code_q   <= ERR_NONE;
        end else begin
            state_q      <= state_d;
            exp_id_q     <= exp_id_d;
            chip_count_q <= chip_count_d;
            retry_cnt_q  <= retry_cnt_d;
            timer_q      <= timer_d;
            err_code_q   <= err_code_d;
        end
    end

    stack_power_table #(
        .DEPTH (MAX_CHIPS)
    ) u_table (
        .clk   (div_8_clk),
        .rst   (rst),
        .clr   (tbl_clr),
        .we    (tbl_we),
        .waddr (f_sender),
        .wdata (f_power),
        .raddr (rd_addr),
        .rdata (rd_power)
    );

    assign chip_count = chip_count_q;
    assign retry_cnt  = retry_cnt_q;
    assign err_code   = err_code_q;
    assign busy       = (state_q == WAIT);
    assign done       = (state_q == DONE);
    assign err        = (state_q == ERROR);

endmodule

// File: tb/tb_stack_id_collector.sv
// Bench for stack_id_collector: directed scenarios plus randomized sessions,
// every cycle compared against a behavioural model of the collector.
module tb_stack_id_collector;

    localparam int unsigned MAXC = 15;
    localparam int unsigned TO   = 64;
    localparam int unsigned RW   = 6;
    localparam int RETRY_MAX     = (1 << RW) - 1;

    localparam int M_IDLE = 0;
    localparam int M_WAIT = 1;
    localparam int M_DONE = 2;
    localparam int M_ERR  = 3;

    logic          div_8_clk = 1'b0;
    logic          rst       = 1'b1;
    logic          start     = 1'b0;
    logic [3:0]    rd_addr   = '0;
    logic [3:0]    rd_power;
    logic [3:0]    chip_count;
    logic [RW-1:0] retry_cnt;
    logic          busy;
    logic          done;
    logic          err;
    logic [1:0]    err_code;

    stack_id_collector_if bus_if ();

    always #5 div_8_clk = ~div_8_clk;

    stack_id_collector #(
        .MAX_CHIPS (MAXC),
        .TIMEOUT   (TO),
        .RETRY_W   (RW)
    ) dut (
        .div_8_clk  (div_8_clk),
        .rst        (rst),
        .start      (start),
        .bus        (bus_if),
        .rd_addr    (rd_addr),
        .rd_power   (rd_power),
        .chip_count (chip_count),
        .retry_cnt  (retry_cnt),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .err_code   (err_code)
    );

    // Reference model state: the expected id is always chip count + 1.
    int m_state;
    int m_count;
    int m_retry;
    int m_idle;
    int m_code;
    int m_table [16];
    bit m_valid = 1'b0;

    logic [3:0]    o_power;
    logic [3:0]    o_count;
    logic [RW-1:0] o_retry;
    logic          o_busy;
    logic          o_done;
    logic          o_err;
    logic [1:0]    o_code;

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_count = 0;
        m_retry = 0;
        m_idle  = 0;
        m_code  = 0;
        for (int i = 0; i < 16; i++) m_table[i] = 0;
    endtask

    task automatic model_step(input bit r, input bit s, input bit v, input logic [31:0] d);
        int snd;
        int nxt;
        int pw;
        if (r) begin
            model_clear();
            m_state = M_IDLE;
            m_valid = 1'b1;
            return;
        end
        if (s) begin
            model_clear();
            m_state = M_WAIT;
            return;
        end
        if (m_state != M_WAIT) return;
        if (v && d[15:0] == 16'hBEEF) begin
            pw  = int'(d[27:24]);
            snd = int'(d[23:20]);
            nxt = int'(d[19:16]);
            if (d[31:28] != 4'hA) begin
                m_state = M_ERR;
                m_code  = 1;
            end else if (snd == m_count + 1 && nxt == (snd + 1) % 16) begin
                m_table[snd] = pw;
                m_count      = snd;
                m_idle       = 0;
                if (snd == MAXC) begin
                    m_state = M_ERR;
                    m_code  = 3;
                end
            end else if (m_count > 0 && snd == m_count && nxt == (snd + 1) % 16) begin
                m_table[snd] = pw;
                m_retry      = (m_retry < RETRY_MAX) ? m_retry + 1 : RETRY_MAX;
                m_idle       = 0;
            end else begin
                m_state = M_ERR;
                m_code  = 2;
            end
        end else begin
            m_idle++;
            if (m_idle == TO) begin
                if (m_count > 0) begin
                    m_state = M_DONE;
                end else begin
                    m_state = M_ERR;
                    m_code  = 3;
                end
            end
        end
    endtask

    // One clock: drive at the falling edge, sample 1 ns later, then advance the model.
    task automatic step(input bit r, input bit s, input bit v, input logic [31:0] d, input int addr);
        @(negedge div_8_clk);
        rst             = r;
        start           = s;
        bus_if.rx_valid = v;
        bus_if.data_in  = d;
        rd_addr         = (addr < 0) ? 4'($urandom_range(0, 15)) : 4'(addr);
        #1;
        o_power = rd_power;
        o_count = chip_count;
        o_retry = retry_cnt;
        o_busy  = busy;
        o_done  = done;
        o_err   = err;
        o_code  = err_code;
        if (m_valid) begin
            check("chip_count", 32'(chip_count), 32'(m_count));
            check("retry_cnt",  32'(retry_cnt),  32'(m_retry));
            check("busy",       32'(busy),       32'(m_state == M_WAIT));
            check("done",       32'(done),       32'(m_state == M_DONE));
            check("err",        32'(err),        32'(m_state == M_ERR));
            check("err_code",   32'(err_code),   32'(m_code));
            check("rd_power",   32'(rd_power),   32'(m_table[rd_addr]));
        end
        model_step(r, s, v, d);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, $urandom, -1);
    endtask

    task automatic send(input logic [31:0] f);
        step(1'b0, 1'b0, 1'b1, f, -1);
    endtask

    task automatic do_start();
        step(1'b0, 1'b1, 1'b0, $urandom, -1);
    endtask

    task automatic probe(input int addr);
        step(1'b0, 1'b0, 1'b0, $urandom, addr);
    endtask

    function automatic logic [31:0] mk_frame(input int pw, input int snd, input int nxt);
        return {4'hA, 4'(pw), 4'(snd), 4'(nxt), 16'hBEEF};
    endfunction

    task automatic random_session();
        int id;
        int nfr;
        int r;
        id  = 1;
        nfr = $urandom_range(1, 16);
        do_start();
        for (int k = 0; k < nfr && id <= int'(MAXC); k++) begin
            idle($urandom_range(0, 25));
            r = $urandom_range(0, 99);
            if (r < 10 && id > 1) begin
                send(mk_frame($urandom_range(0, 15), id - 1, id % 16));
            end else if (r < 13) begin
                send({$urandom_range(0, 1) ? 4'hA : 4'($urandom), 12'($urandom), 16'hBEEF});
            end else if (r < 17) begin
                send({16'($urandom), 16'hCAFE});
            end else if (r < 19) begin
                step(1'b0, 1'b1, 1'b1, mk_frame(1, 1, 2), -1);
                id = 1;
            end else if (r < 20) begin
                step(1'b1, 1'b0, 1'b1, mk_frame(1, id, (id + 1) % 16), -1);
            end else begin
                send(mk_frame($urandom_range(0, 15), id, (id + 1) % 16));
                id++;
            end
        end
        idle(TO + 3);
    endtask

    initial begin
        bus_if.rx_valid = 1'b0;
        bus_if.data_in  = '0;

        step(1'b1, 1'b0, 1'b0, 32'h0, 0);
        step(1'b1, 1'b0, 1'b0, 32'h0, 0);
        probe(5);
        check("rst_count", 32'(o_count), 32'd0);
        check("rst_flags", {29'd0, o_busy, o_done, o_err}, 32'd0);
        check("rst_code",  32'(o_code),  32'd0);

        // Three layers then silence.
        do_start();
        send(32'hA112BEEF);
        send(32'hA123BEEF);
        send(32'hA334BEEF);
        idle(TO + 2);
        probe(1); check("p1_done",  32'(o_done),  32'd1);
        check("p1_count", 32'(o_count), 32'd3);
        check("p1_retry", 32'(o_retry), 32'd0);
        probe(2); check("p1_pow2", 32'(o_power), 32'd1);
        probe(3); check("p1_pow3", 32'(o_power), 32'd3);

        // Retransmission from the top layer.
        do_start();
        send(32'hA112BEEF);
        idle(21);
        send(32'hA212BEEF);
        probe(1);
        check("p2_retry", 32'(o_retry), 32'd1);
        check("p2_pow1",  32'(o_power), 32'd2);
        check("p2_count", 32'(o_count), 32'd1);
        idle(TO + 2);
        probe(1); check("p2_done", 32'(o_done), 32'd1);

        // Out-of-sequence id.
        do_start();
        send(32'hA134BEEF);
        probe(0);
        check("p3_err",   32'(o_err),   32'd1);
        check("p3_code",  32'(o_code),  32'd2);
        check("p3_count", 32'(o_count), 32'd0);

        // Bad sync, then wrong magic followed by silence.
        do_start();
        send(32'hB112BEEF);
        probe(0); check("p4_frame", 32'(o_code), 32'd1);
        do_start();
        send(32'hA112CAFE);
        idle(TO - 3);
        probe(0); check("p4_busy", 32'(o_busy), 32'd1);
        idle(3);
        probe(0);
        check("p4_noresp", 32'(o_code), 32'd3);
        check("p4_err",    32'(o_err),  32'd1);

        // Full stack overflows at MAX_CHIPS.
        do_start();
        for (int i = 1; i <= 15; i++) send(mk_frame(i - 1, i, (i + 1) % 16));
        probe(15);
        check("p5_err",   32'(o_err),   32'd1);
        check("p5_code",  32'(o_code),  32'd3);
        check("p5_count", 32'(o_count), 32'd15);
        check("p5_pow15", 32'(o_power), 32'd14);

        // Reset mid-collection, then start colliding with a frame.
        do_start();
        send(32'hA512BEEF);
        send(32'hA623BEEF);
        step(1'b1, 1'b0, 1'b0, 32'h0, 1);
        probe(1);
        check("p6_count", 32'(o_count), 32'd0);
        check("p6_pow1",  32'(o_power), 32'd0);
        check("p6_flags", {29'd0, o_busy, o_done, o_err}, 32'd0);
        step(1'b0, 1'b1, 1'b1, 32'hA112BEEF, 1);
        probe(1);
        check("p6_drop_busy",  32'(o_busy),  32'd1);
        check("p6_drop_count", 32'(o_count), 32'd0);
        check("p6_drop_pow1",  32'(o_power), 32'd0);

        for (int s = 0; s < 25; s++) random_session();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
